// File: rtl/spi_acq_pkg.sv
// Shared types and sizing helpers for the SPI acquisition sequencer.
package spi_acq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CAPTURE,
    GAP
  } acq_state_e;

  function automatic int frame_bits(input int lead, input int width, input int tail);
    return lead + width + tail;
  endfunction

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_acq_ctrl_if.sv
// Control, ADC-side and sample-side signals of the acquisition sequencer.
interface spi_acq_ctrl_if #(
  parameter int ADC_WIDTH = 8
);
  logic                 start;
  logic                 auto_en;
  logic [ADC_WIDTH-1:0] cur_vd;
  logic                 cs_n;
  logic                 sclk;
  logic                 stp_en;
  logic [ADC_WIDTH-1:0] sample;
  logic                 sample_valid;
  logic                 busy;

  modport master (
    input  start, auto_en, cur_vd,
    output cs_n, sclk, stp_en, sample, sample_valid, busy
  );

  modport slave (
    output start, auto_en, cur_vd,
    input  cs_n, sclk, stp_en, sample, sample_valid, busy
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider: falls on go, then toggles every CLK_DIV cycles while enabled;
// once the last bit has been clocked the next would-be fall is reported as done.
module spi_sclk_gen import spi_acq_pkg::*; #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic go,
  input  logic last,
  output logic sclk,
  output logic rise,
  output logic fall,
  output logic done
);
  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             tick;

  assign tick = en && (div_q == DIV_LAST);
  assign rise = tick && !sclk_q;
  assign fall = go || (tick && sclk_q && !last);
  assign done = tick && sclk_q && last;
  assign sclk = sclk_q;

  always_comb begin
    div_d  = '0;
    sclk_d = 1'b1;
    if (go) begin
      sclk_d = 1'b0;
    end else if (en) begin
      if (tick) begin
        sclk_d = !(sclk_q && !last);
      end else begin
        sclk_d = sclk_q;
        div_d  = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/spi_acq_ctrl.sv
// SPI acquisition sequencer: frames one ADC conversion, gates the shift stage,
// then latches the parallel word and pulses sample_valid.
module spi_acq_ctrl import spi_acq_pkg::*; #(
  parameter int ADC_WIDTH = 8,
  parameter int CLK_DIV   = 2,
  parameter int LEAD_BITS = 2,
  parameter int TAIL_BITS = 2,
  parameter int CS_GAP    = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  spi_acq_ctrl_if.master acq
);
  localparam int FRAME_BITS = frame_bits(LEAD_BITS, ADC_WIDTH, TAIL_BITS);
  localparam int TMR_MAX    = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int TMR_W      = cnt_w(TMR_MAX);
  localparam int BIT_W      = cnt_w(FRAME_BITS);

  localparam logic [TMR_W-1:0] DIV_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W:0]   STP_ON   = (BIT_W+1)'(LEAD_BITS);
  localparam logic [BIT_W:0]   STP_OFF  = (BIT_W+1)'(LEAD_BITS + ADC_WIDTH);

  acq_state_e           state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 cs_n_q, cs_n_d;
  logic                 stp_en_q, stp_en_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [ADC_WIDTH-1:0] sample_q, sample_d;

  logic           sclk_go, sclk_en, sclk_rise, sclk_fall, sclk_done, sclk;
  logic [BIT_W:0] next_fall;

  assign sclk_go   = (state_q == CS_SETUP) && (tmr_q == DIV_LAST);
  assign sclk_en   = (state_q == SHIFT);
  // Index of the falling edge that follows the current sclk rise.
  assign next_fall = {1'b0, bit_cnt_q} + (BIT_W+1)'(1);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (sclk_en),
    .go    (sclk_go),
    .last  (bit_cnt_q == BIT_LAST),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall),
    .done  (sclk_done)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = '0;
    bit_cnt_d = bit_cnt_q;
    cs_n_d    = cs_n_q;
    stp_en_d  = stp_en_q;
    busy_d    = busy_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (acq.start || acq.auto_en) begin
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      CS_SETUP: begin
        if (tmr_q == DIV_LAST) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      SHIFT: begin
        if (sclk_fall) bit_cnt_d = bit_cnt_q + BIT_W'(1);
        // stp_en only moves on rises so it is settled at every fall.
        if (sclk_rise) stp_en_d = (next_fall >= STP_ON) && (next_fall < STP_OFF);
        if (sclk_done) state_d = CS_HOLD;
      end
      CS_HOLD: begin
        if (tmr_q == DIV_LAST) begin
          state_d  = CAPTURE;
          cs_n_d   = 1'b1;
          sample_d = acq.cur_vd;
          valid_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      CAPTURE: state_d = GAP;
      GAP: begin
        if (tmr_q == GAP_LAST) begin
          if (acq.auto_en) begin
            state_d = CS_SETUP;
            cs_n_d  = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      cs_n_q    <= 1'b1;
      stp_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      sample_q  <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      cs_n_q    <= cs_n_d;
      stp_en_q  <= stp_en_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      sample_q  <= sample_d;
    end
  end

  assign acq.cs_n         = cs_n_q;
  assign acq.sclk         = sclk;
  assign acq.stp_en       = stp_en_q;
  assign acq.sample       = sample_q;
  assign acq.sample_valid = valid_q;
  assign acq.busy         = busy_q;
endmodule

// File: tb/tb_spi_acq_ctrl.sv
// Bench for spi_acq_ctrl: two instances (default and fast/short framing), each
// with an ADC model and shift stage; results checked against frame-level timing.
module tb_spi_acq_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic n_rst_a = 1'b0;
  logic n_rst_b = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_acq_ctrl_if #(.ADC_WIDTH(W)) ia ();
  spi_acq_ctrl_if #(.ADC_WIDTH(W)) ib ();

  spi_acq_ctrl #(.ADC_WIDTH(W), .CLK_DIV(2), .LEAD_BITS(2), .TAIL_BITS(2), .CS_GAP(4))
    dut_a (.clk(clk), .n_rst(n_rst_a), .acq(ia));
  spi_acq_ctrl #(.ADC_WIDTH(W), .CLK_DIV(1), .LEAD_BITS(1), .TAIL_BITS(0), .CS_GAP(4))
    dut_b (.clk(clk), .n_rst(n_rst_b), .acq(ib));

  // Per-instance framing: [0] = default build, [1] = CLK_DIV=1/LEAD=1/TAIL=0.
  int cdiv[2] = '{2, 1};
  int nb[2]   = '{12, 9};
  int tl[2]   = '{2, 0};
  int gap     = 4;

  logic cs_w[2], sclk_w[2], stp_w[2], sv_w[2], busy_w[2];
  logic [W-1:0] smp_w[2];
  assign cs_w[0] = ia.cs_n;    assign cs_w[1] = ib.cs_n;
  assign sclk_w[0] = ia.sclk;  assign sclk_w[1] = ib.sclk;
  assign stp_w[0] = ia.stp_en; assign stp_w[1] = ib.stp_en;
  assign sv_w[0] = ia.sample_valid; assign sv_w[1] = ib.sample_valid;
  assign busy_w[0] = ia.busy;  assign busy_w[1] = ib.busy;
  assign smp_w[0] = ia.sample; assign smp_w[1] = ib.sample;

  logic [W-1:0] dq[2][$];
  logic [31:0]  bits[2];
  logic         miso[2];
  logic [W-1:0] sr[2] = '{8'h00, 8'h00};
  int fall[2], stpf[2], first_fall[2], last_fall[2];
  int unstable[2] = '{0, 0};
  logic pcs[2] = '{1'b1, 1'b1};
  logic psclk[2] = '{1'b1, 1'b1};
  logic pstp[2] = '{1'b0, 1'b0};
  logic pbusy[2] = '{1'b0, 1'b0};
  int cs_fall_t[2][$], cs_rise_t[2][$], busy_fall_t[2][$], sv_t[2][$];
  int falls_q[2][$], stpf_q[2][$], span_q[2][$];
  logic [W-1:0] sv_v[2][$];

  assign ia.cur_vd = sr[0];
  assign ib.cur_vd = sr[1];

  // ADC drives its frame MSB first, advancing on sclk rise; shift stage shifts
  // on sclk fall when stp_en is high.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pcs[k] === 1'b1 && cs_w[k] === 1'b0) begin
        bits[k] = (dq[k].size() > 0) ? (32'(dq[k].pop_front()) << tl[k]) : 32'd0;
        fall[k] = 0;
        stpf[k] = 0;
        miso[k] = bits[k][nb[k]-1];
        cs_fall_t[k].push_back(cyc);
      end
      if (pcs[k] === 1'b0 && cs_w[k] === 1'b1) begin
        cs_rise_t[k].push_back(cyc);
        falls_q[k].push_back(fall[k]);
        stpf_q[k].push_back(stpf[k]);
        span_q[k].push_back(last_fall[k] - first_fall[k]);
      end
      if (cs_w[k] === 1'b0 && psclk[k] === 1'b1 && sclk_w[k] === 1'b0) begin
        if (stp_w[k] !== pstp[k]) unstable[k]++;
        if (stp_w[k] === 1'b1) begin
          sr[k] = {sr[k][W-2:0], miso[k]};
          stpf[k]++;
        end
        if (fall[k] == 0) first_fall[k] = cyc;
        last_fall[k] = cyc;
        fall[k]++;
      end
      if (cs_w[k] === 1'b0 && psclk[k] === 1'b0 && sclk_w[k] === 1'b1 && fall[k] < nb[k])
        miso[k] = bits[k][nb[k]-1-fall[k]];
      if (sv_w[k] === 1'b1) begin
        sv_t[k].push_back(cyc);
        sv_v[k].push_back(smp_w[k]);
      end
      if (pbusy[k] === 1'b1 && busy_w[k] === 1'b0) busy_fall_t[k].push_back(cyc);
      pcs[k]   = cs_w[k];
      psclk[k] = sclk_w[k];
      pstp[k]  = stp_w[k];
      pbusy[k] = busy_w[k];
    end
  end

  // Frame-level timing: setup + full SHIFT + hold, then CAPTURE + GAP.
  function automatic int t_valid(input int k);
    return cdiv[k] + 2 * cdiv[k] * nb[k] + cdiv[k];
  endfunction
  function automatic int t_idle(input int k);
    return t_valid(k) + 1 + gap;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_mon(input int k);
    cs_fall_t[k].delete(); cs_rise_t[k].delete(); busy_fall_t[k].delete();
    sv_t[k].delete(); sv_v[k].delete();
    falls_q[k].delete(); stpf_q[k].delete(); span_q[k].delete();
  endtask

  task automatic one_shot(input int k, input logic [W-1:0] d, output int e0);
    dq[k].push_back(d);
    if (k == 0) ia.start = 1'b1; else ib.start = 1'b1;
    e0 = cyc + 1;
    tick(1);
    ia.start = 1'b0;
    ib.start = 1'b0;
  endtask

  task automatic wait_busy_fall(input int k, input int n, input int budget, input string tag);
    int i = 0;
    while (busy_fall_t[k].size() < n && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, 64'(busy_fall_t[k].size()), 64'(n));
  endtask

  initial begin
    int e0;
    int bad;
    logic [W-1:0] d;

    ia.start = 1'b0; ia.auto_en = 1'b0;
    ib.start = 1'b0; ib.auto_en = 1'b0;

    tick(3);
    chk("rst_cs_n", ia.cs_n, 1'b1);
    chk("rst_sclk", ia.sclk, 1'b1);
    chk("rst_stp_en", ia.stp_en, 1'b0);
    chk("rst_busy", ia.busy, 1'b0);
    chk("rst_sample", ia.sample, 8'h00);
    chk("rst_valid", ia.sample_valid, 1'b0);
    n_rst_a = 1'b1;
    n_rst_b = 1'b1;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      for (int k = 0; k < 2; k++)
        if (cs_w[k] !== 1'b1 || sclk_w[k] !== 1'b1 || stp_w[k] !== 1'b0 ||
            busy_w[k] !== 1'b0 || smp_w[k] !== 8'h00 || sv_w[k] !== 1'b0) bad++;
    end
    chk("idle_100_cycles", 64'(bad), 64'd0);

    // Single-shot 0xA5.
    clear_mon(0);
    one_shot(0, 8'hA5, e0);
    wait_busy_fall(0, 1, 200, "a5_done");
    tick(3);
    chk("a5_cs_fall_t", 64'(cs_fall_t[0][0] - e0), 64'd0);
    chk("a5_sclk_falls", 64'(falls_q[0][0]), 64'(nb[0]));
    chk("a5_stp_falls", 64'(stpf_q[0][0]), 64'(W));
    chk("a5_valid_t", 64'(sv_t[0][0] - e0), 64'(t_valid(0)));
    chk("a5_n_valid", 64'(sv_t[0].size()), 64'd1);
    chk("a5_sample", sv_v[0][0], 8'hA5);
    chk("a5_held", ia.sample, 8'hA5);
    chk("a5_busy_low_t", 64'(busy_fall_t[0][0] - e0), 64'(t_idle(0)));

    // start re-pulsed mid-frame must be ignored.
    clear_mon(0);
    d = 8'($urandom_range(0, 255));
    one_shot(0, d, e0);
    tick(e0 + 19 - cyc);
    ia.start = 1'b1;
    tick(1);
    ia.start = 1'b0;
    wait_busy_fall(0, 1, 200, "repulse_done");
    tick(80);
    chk("repulse_n_frames", 64'(cs_fall_t[0].size()), 64'd1);
    chk("repulse_n_valid", 64'(sv_t[0].size()), 64'd1);
    chk("repulse_sample", sv_v[0][0], d);
    chk("repulse_valid_t", 64'(sv_t[0][0] - e0), 64'(t_valid(0)));

    // Free-running: 0x3C then 0xFF, auto_en dropped during the second frame.
    clear_mon(0);
    dq[0].push_back(8'h3C);
    dq[0].push_back(8'hFF);
    ia.auto_en = 1'b1;
    e0 = cyc + 1;
    tick(1);
    for (int i = 0; i < 200 && sv_t[0].size() < 1; i++) tick(1);
    tick(30);
    ia.auto_en = 1'b0;
    wait_busy_fall(0, 1, 300, "auto_done");
    tick(80);
    chk("auto_n_frames", 64'(cs_fall_t[0].size()), 64'd2);
    chk("auto_frame_period", 64'(cs_fall_t[0][1] - cs_fall_t[0][0]), 64'(t_idle(0)));
    chk("auto_cs_high", 64'(cs_fall_t[0][1] - cs_rise_t[0][0]), 64'(1 + gap));
    chk("auto_n_valid", 64'(sv_t[0].size()), 64'd2);
    chk("auto_sample0", sv_v[0][0], 8'h3C);
    chk("auto_sample1", sv_v[0][1], 8'hFF);
    chk("auto_valid_period", 64'(sv_t[0][1] - sv_t[0][0]), 64'(t_idle(0)));
    chk("auto_busy_low_t", 64'(busy_fall_t[0][0] - e0), 64'(2 * t_idle(0)));

    // Reset in the middle of SHIFT.
    clear_mon(0);
    d = 8'($urandom_range(0, 255));
    one_shot(0, d, e0);
    tick(e0 + 29 - cyc);
    chk("rst_mid_cs_low", ia.cs_n, 1'b0);
    n_rst_a = 1'b0;
    #1;
    chk("rst_mid_cs_n", ia.cs_n, 1'b1);
    chk("rst_mid_sclk", ia.sclk, 1'b1);
    chk("rst_mid_stp_en", ia.stp_en, 1'b0);
    chk("rst_mid_sample", ia.sample, 8'h00);
    chk("rst_mid_busy", ia.busy, 1'b0);
    tick(2);
    n_rst_a = 1'b1;
    tick(2);
    clear_mon(0);
    one_shot(0, 8'h5A, e0);
    wait_busy_fall(0, 1, 200, "post_rst_done");
    tick(2);
    chk("post_rst_n_valid", 64'(sv_t[0].size()), 64'd1);
    chk("post_rst_sample", sv_v[0][0], 8'h5A);
    chk("post_rst_valid_t", 64'(sv_t[0][0] - e0), 64'(t_valid(0)));
    chk("post_rst_falls", 64'(falls_q[0][0]), 64'(nb[0]));

    // Fast build: 0x81 then random words.
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'h81 : 8'($urandom_range(0, 255));
      clear_mon(1);
      tick($urandom_range(1, 6));
      one_shot(1, d, e0);
      wait_busy_fall(1, 1, 100, "b_done");
      tick(2);
      chk("b_sample", sv_v[1][0], d);
      chk("b_n_valid", 64'(sv_t[1].size()), 64'd1);
      chk("b_valid_t", 64'(sv_t[1][0] - e0), 64'(t_valid(1)));
      chk("b_busy_low_t", 64'(busy_fall_t[1][0] - e0), 64'(t_idle(1)));
      chk("b_sclk_falls", 64'(falls_q[1][0]), 64'(nb[1]));
      chk("b_stp_falls", 64'(stpf_q[1][0]), 64'(W));
      chk("b_fall_span", 64'(span_q[1][0]), 64'(2 * cdiv[1] * (nb[1] - 1)));
    end

    chk("a_stp_stable", 64'(unstable[0]), 64'd0);
    chk("b_stp_stable", 64'(unstable[1]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
